shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data width; legal values are powers of two from 4 to 64.
REQ-002 The module SHALL have derived parameter SHW, default $clog2(WIDTH), shift-amount width and pipeline depth.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the input operation is present.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the module accepts the input this cycle.
REQ-007 The module SHALL have port din, input, WIDTH bits: the operand.
REQ-008 The module SHALL have port shamt, input, SHW bits: the shift amount, 0..WIDTH-1.
REQ-009 The module SHALL have port mode, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 The module SHALL have port out_valid, output, 1 bit: dout holds a result.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The module SHALL have port dout, output, WIDTH bits: the shifted result.
REQ-013 The module SHALL have port zero, output, 1 bit: dout==0, qualified by out_valid.

Function
REQ-014 The module SHALL implement an SHW-stage pipeline in which stage k (k=0..SHW-1) conditionally shifts by 2^k when shamt bit k is set, and each stage register SHALL carry data, the unused shamt bits, mode and a valid bit.
REQ-015 Stage k fill bits SHALL be: SLL -> 0 into the LSBs; SRL -> 0 into the MSBs; SRA -> the original din[WIDTH-1] into the MSBs; ROR -> the bits shifted out at the LSB end wrapped into the MSBs.
REQ-016 The global advance enable SHALL be adv = !out_valid || out_ready, in_ready SHALL equal adv combinationally, and when adv=0 every stage SHALL hold.
REQ-017 An input SHALL be accepted when in_valid && in_ready, and its result SHALL appear with out_valid=1 exactly SHW cycles after acceptance when there is no backpressure.
REQ-018 With continuous in_valid=1 and out_ready=1, the module SHALL sustain throughput of one result per cycle.
REQ-019 A cycle with in_valid=0 and adv=1 SHALL insert a bubble (valid=0) into stage 0, and bubbles SHALL propagate without producing out_valid.
REQ-020 dout and zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 shamt=0 in any mode SHALL yield dout=din after SHW cycles.
REQ-022 Simultaneous acceptance of a new input and consumption of the output SHALL move the pipeline with no loss or duplication.
REQ-023 Results SHALL emerge in acceptance order.

Reset
REQ-024 While rst_n=0, all stage valid bits and out_valid SHALL be 0 immediately, asynchronously.
REQ-025 While rst_n=0, dout SHALL be 0 and zero SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight operations.
REQ-027 In the first cycle after rst_n deasserts, in_ready SHALL be 1.
REQ-028 Data registers not covered by REQ-025 SHALL be permitted to be unreset.

Configuration
REQ-029 Macro SHIFT_PIPE_ROTATE_EN defined: mode 11 SHALL perform ROR per REQ-015.
REQ-030 Macro SHIFT_PIPE_ROTATE_EN undefined: no wrap-around path SHALL be built, and mode 11 SHALL behave exactly as SRL.

Verification (WIDTH=8, SHW=3)
REQ-031 The bench SHALL check: SRA, din=8'h96, shamt=3, out_ready=1 -> out_valid rises 3 cycles later, dout=8'hF2, zero=0.
REQ-032 The bench SHALL check: SLL 8'h96 shamt=3 -> 8'hB0; SRL 8'h96 shamt=7 -> 8'h01; SLL 8'h80 shamt=1 -> 8'h00 with zero=1.
REQ-033 The bench SHALL check: ROR 8'h96 shamt=3 -> 8'hD2 with SHIFT_PIPE_ROTATE_EN defined, and 8'h12 without it.
REQ-034 The bench SHALL check: 4 back-to-back inputs, out_ready held 0 for 5 cycles after the first out_valid -> in_ready=0 while stalled, dout frozen, then all 4 results emerge in order on consecutive cycles with none lost.
REQ-035 The bench SHALL check: 2 inputs in flight, rst_n pulsed low for 1 cycle mid-pipeline -> out_valid=0 immediately, no result ever emerges, and the next input completes in 3 cycles.
REQ-036 The bench SHALL check: a random stream with random in_valid/out_ready gaps against a reference model -> results match exactly and in order.

Source files
------------

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: one binary-weighted shift stage per shamt bit.
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROR (or SRL when rotation is not built).
// Optional feature macro: SHIFT_PIPE_ROTATE_EN builds the rotate-right path.
// The valid/ready handshake stalls the whole pipe when the output is held.
module shift_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             zero
);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;
  localparam logic [1:0] ModeRor = 2'b11;

  // One conditional shift by a fixed amount. SRA fills from the current MSB,
  // which is still the original sign because only right shifts precede it.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] x,
                                                   input logic             en,
                                                   input logic [1:0]       md,
                                                   input int unsigned      amt);
    logic [WIDTH-1:0] r;
    r = x;
    if (en) begin
      unique case (md)
        ModeSll: r = x << amt;
        ModeSrl: r = x >> amt;
        ModeSra: r = $signed(x) >>> amt;
`ifdef SHIFT_PIPE_ROTATE_EN
        ModeRor: r = (x >> amt) | (x << (WIDTH - amt));
`else
        ModeRor: r = x >> amt;
`endif
      endcase
    end
    return r;
  endfunction

  // Per-stage combinational inputs (stage 0 reads the ports directly).
  logic [WIDTH-1:0] stg_x  [SHW];
  logic [SHW-1:0]   stg_sh [SHW];
  logic [1:0]       stg_md [SHW];
  logic [WIDTH-1:0] data_d [SHW];

  // Inter-stage registers; the last stage's data lives in dout_q.
  logic [WIDTH-1:0] data_q [SHW-1];
  logic [1:0]       mode_q [SHW-1];
  logic [SHW-1:0]   sh_q   [SHW-1];
  logic [SHW-1:0]   valid_q;
  logic [WIDTH-1:0] dout_q;
  logic             adv;

  // Remaining shamt bits are kept right-aligned, so bit 0 always selects the
  // current stage's shift.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stg_x[k]  = din;
      assign stg_sh[k] = shamt;
      assign stg_md[k] = mode;
    end else begin : g_body
      assign stg_x[k]  = data_q[k-1];
      assign stg_sh[k] = sh_q[k-1];
      assign stg_md[k] = mode_q[k-1];
    end
    assign data_d[k] = stage_shift(stg_x[k], stg_sh[k][0], stg_md[k], 32'd1 << k);
  end

  // Whole pipe moves together whenever the output slot is free or drained.
  assign adv       = !valid_q[SHW-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[SHW-1];
  assign dout      = dout_q;
  assign zero      = valid_q[SHW-1] && (dout_q == '0);

  // Stage valid bits: a new op or a bubble enters stage 0 on every advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= {valid_q[SHW-2:0], in_valid};
    end
  end

  // Intermediate payload: no reset needed, qualified by valid_q.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < SHW - 1; k++) begin
        data_q[k] <= data_d[k];
        mode_q[k] <= stg_md[k];
        sh_q[k]   <= stg_sh[k] >> 1;
      end
    end
  end

  // Output data register: reset so dout reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (adv) begin
      dout_q <= data_d[SHW-1];
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=8). Expected results are queued
// at acceptance and a monitor compares them as the DUT hands results out.
module tb_shift_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int lat;
  int cnt;
  logic [8:0] q [$];
  logic [8:0] mon_e;
  logic stim_done;

`ifdef SHIFT_PIPE_ROTATE_EN
  localparam bit RotEn = 1'b1;
  localparam logic [7:0] RorExp96 = 8'hD2;
  localparam logic [7:0] RorExp01 = 8'h80;
`else
  localparam bit RotEn = 1'b0;
  localparam logic [7:0] RorExp96 = 8'h12;
  localparam logic [7:0] RorExp01 = 8'h00;
`endif

  shift_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .shamt     (shamt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Bit-by-bit reference shifter.
  function automatic logic [7:0] ref_shift(input logic [7:0] x, input int s,
                                           input logic [1:0] m);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (m == 2'b00) begin
        if (i >= s) r[i] = x[i-s];
        else        r[i] = 1'b0;
      end else if (m == 2'b11 && RotEn) begin
        r[i] = x[(i+s)%8];
      end else begin
        if (i + s < 8)      r[i] = x[i+s];
        else if (m == 2'b10) r[i] = x[7];
        else                r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Monitor: a result is taken on the next edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got dout=%0h, want no output", dout);
      end else begin
        mon_e = q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, mon_e[7:0]});
        chk("zero", {31'd0, zero}, {31'd0, mon_e[8]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                      input logic [7:0] e);
    int n = 0;
    in_valid = 1'b1;
    din      = d;
    shamt    = s;
    mode     = m;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({(e == 8'h00), e});
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Returns at the first negedge with out_valid=1 (or after a bound).
  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 0; rst_n = 1; in_valid = 0; din = 0; shamt = 0; mode = 0; out_ready = 0;
    stim_done = 0;
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    out_ready = 1;

    // SRA latency and value
    send(8'h96, 3'd3, 2'b10, 8'hF2);
    wait_valid();
    lat = cyc - acc_cyc;
    chk("latency_sra", lat, 32'd3);
    @(posedge clk);
    #1;
    drain();

    // Directed vectors, back to back
    send(8'h96, 3'd3, 2'b00, 8'hB0);
    send(8'h96, 3'd7, 2'b01, 8'h01);
    send(8'h80, 3'd1, 2'b00, 8'h00);
    send(8'h96, 3'd3, 2'b11, RorExp96);
    send(8'hA5, 3'd0, 2'b00, 8'hA5);
    send(8'hA5, 3'd0, 2'b01, 8'hA5);
    send(8'hA5, 3'd0, 2'b10, 8'hA5);
    send(8'hA5, 3'd0, 2'b11, 8'hA5);
    send(8'h64, 3'd2, 2'b10, 8'h19);
    send(8'h80, 3'd7, 2'b10, 8'hFF);
    send(8'h01, 3'd1, 2'b11, RorExp01);
    send(8'h96, 3'd5, 2'b01, 8'h04);
    drain();

    // Backpressure: stall 5 cycles after first result, then burst out
    out_ready = 0;
    fork
      begin
        send(8'h0F, 3'd2, 2'b00, 8'h3C);
        send(8'hF0, 3'd4, 2'b01, 8'h0F);
        send(8'h81, 3'd1, 2'b10, 8'hC0);
        send(8'h01, 3'd7, 2'b00, 8'h80);
      end
      begin
        wait_valid();
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_dout", {24'd0, dout}, 32'h3C);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("burst_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    @(posedge clk);
    #1;
    drain();

    // Mid-pipeline reset discards in-flight work
    out_ready = 0;
    send(8'h96, 3'd1, 2'b01, 8'h4B);
    send(8'h96, 3'd2, 2'b00, 8'h58);
    wait_valid();
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    out_ready = 1;
    chk("in_ready_after_midrst", {31'd0, in_ready}, 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_ghost_results", cnt, 32'd0);
    @(posedge clk);
    #1;
    send(8'hC3, 3'd2, 2'b10, 8'hF0);
    wait_valid();
    lat = cyc - acc_cyc;
    chk("latency_after_rst", lat, 32'd3);
    @(posedge clk);
    #1;
    drain();

    // Random stream with random gaps and backpressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [7:0] d;
          logic [2:0] s;
          logic [1:0] m;
          d = 8'($urandom);
          s = 3'($urandom_range(0, 7));
          m = 2'($urandom_range(0, 3));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(d, s, m, ref_shift(d, int'(s), m));
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
